// File: rtl/sort_rf_arbiter_if.sv
// sort_rf_arbiter_if
//  Host edit port of the sort register-file arbiter.
//  Ports (signals):
//    req    host access request, held high until ack
//    we     1 = write, 0 = read; stable while req = 1
//    addr   register-file address; stable while req = 1
//    wdata  write data; stable while req = 1
//    ack    one-cycle completion pulse
//    rdata  read result, valid with ack, held until the next read
//  modport master : host side, modport slave : arbiter side.
interface sort_rf_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sort_rf_arbiter.sv
// sort_rf_arbiter
//  Shares a 32x16 register file (two async read ports, one write port)
//  between the host edit port and the sort engine, sequences a sort run
//  (exe pulse, RF hand-over while the sorter is busy, hand-back), latches
//  the sorter's cycle count at completion and guards the run with a
//  start watchdog and a run timeout.
//  Ports:
//    clk, rst                 clock, asynchronous active-high reset
//    host                     host edit port (sort_rf_arbiter_if.slave)
//    start                    sort request pulse
//    busy / done / err        run status, completion pulse, sticky error
//    cycles                   srt_delay latched at completion
//    srt_exe                  one-cycle start pulse to the sorter
//    srt_busy, srt_delay      sorter status and cycle counter
//    srt_add0/1, srt_wa/wd/we sorter RF access
//    rf_ra0/1, rf_rd0/1       RF read ports (rf_rd0/1 feed the sorter directly)
//    rf_wa/wd/we              RF write port
module sort_rf_arbiter #(
    parameter int          AW         = 5,
    parameter int          DW         = 16,
    parameter int          START_WAIT = 4,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    sort_rf_arbiter_if.slave host,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   cycles,
    output logic          srt_exe,
    input  logic          srt_busy,
    input  logic [15:0]   srt_delay,
    input  logic [AW-1:0] srt_add0,
    input  logic [AW-1:0] srt_add1,
    input  logic [AW-1:0] srt_wa,
    input  logic [DW-1:0] srt_wd,
    input  logic          srt_we,
    output logic [AW-1:0] rf_ra0,
    output logic [AW-1:0] rf_ra1,
    input  logic [DW-1:0] rf_rd0,
    input  logic [DW-1:0] rf_rd1,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          rf_we
);

    typedef enum logic [2:0] {IDLE, H_RD, H_WR, ACK, ARM, RUN, FIN, ERRS} state_t;

    localparam int WW = $clog2(START_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(START_WAIT - 1);

    state_t        state_q, state_d;
    logic          pend_q;
    logic [AW-1:0] haddr_q;
    logic [DW-1:0] hwdata_q;
    logic [DW-1:0] rdata_q;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   run_cnt;
    logic          grant_sort;
    logic          accept;

    // A start is accepted only out of IDLE; pending or live start beats host_req.
    assign accept     = (state_q == IDLE) && (start || pend_q);
    assign host.rdata = rdata_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start || pend_q) state_d = ARM;
                else if (host.req)   state_d = host.we ? H_WR : H_RD;
            end
            H_RD, H_WR: state_d = ACK;
            ACK:        state_d = IDLE;
            ARM: begin
                if (srt_busy)                   state_d = RUN;
                else if (wait_cnt == WAIT_LAST) state_d = ERRS;
            end
            RUN: begin
                if (!srt_busy)              state_d = FIN;
                else if (run_cnt == TIMEOUT) state_d = ERRS;
            end
            FIN, ERRS:  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output decode and RF port mux; grant follows state so a reset
    // returns the ports to the host (and drops rf_we) without a clock.
    always_comb begin
        grant_sort = (state_q == ARM) || (state_q == RUN);
        host.ack   = (state_q == ACK);
        srt_exe    = (state_q == ARM) && (wait_cnt == '0);
        done       = (state_q == FIN);
        if (grant_sort) begin
            rf_ra0 = srt_add0;
            rf_ra1 = srt_add1;
            rf_wa  = srt_wa;
            rf_wd  = srt_wd;
            rf_we  = srt_we;
        end else begin
            rf_ra0 = haddr_q;
            rf_ra1 = '0;
            rf_wa  = haddr_q;
            rf_wd  = hwdata_q;
            rf_we  = (state_q == H_WR);
        end
    end

    // Control and captured-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cycles   <= '0;
            wait_cnt <= '0;
            run_cnt  <= '0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            // Starts arriving mid host-transaction merge into one pending request.
            if (accept)
                pend_q <= 1'b0;
            else if (start && (state_q == H_RD || state_q == H_WR || state_q == ACK))
                pend_q <= 1'b1;

            if (accept)
                busy <= 1'b1;
            else if (state_q == FIN || state_q == ERRS)
                busy <= 1'b0;

            if (accept)
                err <= 1'b0;
            else if (state_q == ERRS)
                err <= 1'b1;

            if (state_q == FIN)
                cycles <= srt_delay;

            // wait_cnt is zero on ARM entry, which also marks the srt_exe cycle.
            if (state_q == ARM) wait_cnt <= wait_cnt + 1'b1;
            else                wait_cnt <= '0;

            if (state_q == ARM)
                run_cnt <= '0;
            else if (state_q == RUN && run_cnt != TIMEOUT)
                run_cnt <= run_cnt + 16'd1;

            if (state_q == IDLE && !start && !pend_q && host.req) begin
                haddr_q  <= host.addr;
                hwdata_q <= host.wdata;
            end

            if (state_q == H_RD)
                rdata_q <= rf_rd0;
        end
    end

endmodule

// File: tb/tb_sort_rf_arbiter.sv
// tb_sort_rf_arbiter
//  Directed bench for sort_rf_arbiter: a behavioural 32x16 register file,
//  a bubble-sort engine stub (optionally dead: never raises busy) and
//  host-port stimulus with hand-computed expected values.
module tb_sort_rf_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err, srt_exe;
    logic [15:0] cycles;
    logic        srt_busy;
    logic [15:0] srt_delay;
    logic [4:0]  srt_add0, srt_add1, srt_wa;
    logic [15:0] srt_wd;
    logic        srt_we;
    logic [4:0]  rf_ra0, rf_ra1, rf_wa;
    logic [15:0] rf_rd0, rf_rd1, rf_wd;
    logic        rf_we;

    int n_tests = 0;
    int n_fail  = 0;

    sort_rf_arbiter_if #(.AW(5), .DW(16)) host ();

    sort_rf_arbiter #(.AW(5), .DW(16), .START_WAIT(4), .TIMEOUT(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .host(host),
        .start(start), .busy(busy), .done(done), .err(err), .cycles(cycles),
        .srt_exe(srt_exe), .srt_busy(srt_busy), .srt_delay(srt_delay),
        .srt_add0(srt_add0), .srt_add1(srt_add1), .srt_wa(srt_wa),
        .srt_wd(srt_wd), .srt_we(srt_we),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we)
    );

    always #5 clk = ~clk;

    // Register file: asynchronous reads, synchronous write.
    logic [15:0] rf_mem [32];
    initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    assign rf_rd0 = rf_mem[rf_ra0];
    assign rf_rd1 = rf_mem[rf_ra1];
    always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

    // Sorter stub: bubble sort, compare cycle (write lower to j) then
    // swap cycle (write saved upper to j+1) when out of order.
    logic        stub_dead = 1'b0;
    logic [1:0]  s_st;
    logic [4:0]  s_j, s_pass, s_jn, s_pn;
    logic [15:0] s_save;
    logic        s_last;

    always_comb begin
        s_last   = (s_j == 5'd30) && (s_pass == 5'd30);
        s_jn     = (s_j == 5'd30) ? 5'd0 : s_j + 5'd1;
        s_pn     = (s_j == 5'd30) ? s_pass + 5'd1 : s_pass;
        srt_add0 = s_j;
        srt_add1 = s_j + 5'd1;
        srt_we   = (s_st == 2'd2) || ((s_st == 2'd1) && (rf_rd0 > rf_rd1));
        srt_wa   = (s_st == 2'd2) ? s_j + 5'd1 : s_j;
        srt_wd   = (s_st == 2'd2) ? s_save : rf_rd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_st <= 2'd0; srt_busy <= 1'b0; srt_delay <= '0;
            s_j <= '0; s_pass <= '0; s_save <= '0;
        end else begin
            case (s_st)
                2'd0: if (srt_exe && !stub_dead) begin
                    s_st <= 2'd1; srt_busy <= 1'b1; srt_delay <= '0;
                    s_j <= '0; s_pass <= '0;
                end
                default: begin
                    srt_delay <= srt_delay + 16'd1;
                    if (s_st == 2'd1 && rf_rd0 > rf_rd1) begin
                        s_save <= rf_rd0;
                        s_st   <= 2'd2;
                    end else begin
                        s_j    <= s_jn;
                        s_pass <= s_pn;
                        if (s_last) begin
                            s_st <= 2'd0; srt_busy <= 1'b0;
                        end else begin
                            s_st <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_access(input bit we, input logic [4:0] a, input logic [15:0] d,
                               output logic [15:0] rd);
        int n;
        @(negedge clk);
        host.req = 1'b1; host.we = we; host.addr = a; host.wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!host.ack && n < 5000);
        if (!host.ack) check("ack_timeout", 0, 1);
        rd = host.rdata;
        host.req = 1'b0;
    endtask

    task automatic load_desc();
        logic [15:0] rd;
        for (int i = 0; i < 32; i++) host_access(1'b1, 5'(i), 16'((32 - i) * 37), rd);
    endtask

    task automatic check_sorted(input string tag);
        logic [15:0] rd;
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            host_access(1'b0, 5'(i), 16'h0, rd);
            if (rd !== 16'((i + 1) * 37)) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Walks negedges from the current one until done, counting exe pulses and acks.
    task automatic wait_done(output int exe, output int acks, output bit got);
        exe = 0; acks = 0; got = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (srt_exe)  exe++;
            if (host.ack) acks++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_sort(input string tag);
        int exe, acks;
        bit got;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_exe"}, srt_exe, 1);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        wait_done(exe, acks, got);
        check({tag, "_done"}, got, 1);
        check({tag, "_exe_extra"}, exe, 0);
        @(negedge clk);
        check({tag, "_cycles"}, cycles, srt_delay);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int exe, acks, n, dn;
        bit got;

        host.req = 1'b0; host.we = 1'b0; host.addr = '0; host.wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outs", {busy, done, err, srt_exe, rf_we, host.ack, cycles, host.rdata}, 0);
        rst = 1'b0;

        // Write 00A5 @3 then read it back
        @(negedge clk);
        host.req = 1'b1; host.we = 1'b1; host.addr = 5'd3; host.wdata = 16'h00A5;
        @(negedge clk);
        check("wr_we", rf_we, 1);
        check("wr_wa", rf_wa, 3);
        check("wr_wd", rf_wd, 16'h00A5);
        check("wr_ack_early", host.ack, 0);
        @(negedge clk);
        check("wr_ack", host.ack, 1);
        check("wr_we_off", rf_we, 0);
        host.req = 1'b0;
        @(negedge clk);
        check("ack_pulse", host.ack, 0);
        host.req = 1'b1; host.we = 1'b0; host.addr = 5'd3;
        @(negedge clk);
        check("rd_ack_early", host.ack, 0);
        check("rd_we", rf_we, 0);
        @(negedge clk);
        check("rd_ack", host.ack, 1);
        check("rd_data", host.rdata, 16'h00A5);
        host.req = 1'b0;

        // Full sort of 32 descending values
        load_desc();
        do_sort("sort1");
        check_sorted("sort1_order");

        // start and host_req in the same IDLE cycle: sort first, ack after done
        @(negedge clk);
        start = 1'b1; host.req = 1'b1; host.we = 1'b0; host.addr = 5'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(exe, acks, got);
        check("both_done", got, 1);
        check("both_exe", exe, 1);
        check("both_no_early_ack", acks, 0);
        n = 0;
        while (!host.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("both_ack_after", host.ack, 1);
        check("both_rdata", host.rdata, 16'd37);
        host.req = 1'b0;

        // start during H_WR: write completes, then one sort from the pending request
        @(negedge clk);
        host.req = 1'b1; host.we = 1'b1; host.addr = 5'd5; host.wdata = 16'd0;
        @(negedge clk);
        check("pend_hwr_we", rf_we, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pend_ack", host.ack, 1);
        host.req = 1'b0;
        @(negedge clk);
        check("pend_idle_exe", srt_exe, 0);
        @(negedge clk);
        check("pend_exe", srt_exe, 1);
        wait_done(exe, acks, got);
        check("pend_done", got, 1);
        check("pend_exe_once", exe, 1);
        host_access(1'b0, 5'd0, 16'h0, rd);
        check("pend_rd0", rd, 16'd0);
        host_access(1'b0, 5'd6, 16'h0, rd);
        check("pend_rd6", rd, 16'd259);

        // Dead sorter: watchdog error, no done, host access still works
        stub_dead = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("dead_exe", srt_exe, 1);
        n = 0; dn = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
            if (done) dn++;
        end
        check("dead_err_lat", n, 5);
        check("dead_no_done", dn, 0);
        check("dead_busy_off", busy, 0);
        stub_dead = 1'b0;
        host_access(1'b1, 5'd9, 16'h1234, rd);
        host_access(1'b0, 5'd9, 16'h0, rd);
        check("dead_host_rd", rd, 16'h1234);
        check("dead_err_sticky", err, 1);

        // Next accepted start clears err
        load_desc();
        do_sort("sort2");
        check_sorted("sort2_order");

        // Reset in RUN, then a clean sort
        load_desc();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        check("run_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_run_outs", {busy, done, err, srt_exe, rf_we, host.ack, cycles,
                               rf_wa, rf_ra0, rf_ra1}, 0);
        @(negedge clk);
        rst = 1'b0;
        load_desc();
        do_sort("sort3");
        check_sorted("sort3_order");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
